// File: rtl/crop_roi_locator_pkg.sv
// Shared definitions for the crop ROI locator: default geometry, pixel type, FSM states
// and the crop-origin clamp used by both the RTL and its bench model.
package crop_pkg;

  localparam int unsigned DEF_PIXEL_BIT_WIDTH  = 16;
  localparam int unsigned DEF_IN_ROWS          = 100;
  localparam int unsigned DEF_IN_COLS          = 160;
  localparam int unsigned DEF_OUT_ROWS         = 48;
  localparam int unsigned DEF_OUT_COLS         = 48;
  localparam int unsigned DEF_IMG_ROW_BITWIDTH = 10;
  localparam int unsigned DEF_IMG_COL_BITWIDTH = 10;

  typedef logic signed [DEF_PIXEL_BIT_WIDTH-1:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    EMIT,
    DONE
  } state_e;

  // Window origin that centres on pos; compared before subtracting so it never underflows.
  function automatic int unsigned clamp_origin(int unsigned pos, int unsigned half,
                                               int unsigned max_origin);
    int unsigned d;
    if (pos < half) return 0;
    d = pos - half;
    return (d > max_origin) ? max_origin : d;
  endfunction

endpackage

// File: rtl/crop_roi_locator_if.sv
// Block-level control plus pixel input and crop-origin output streams of crop_roi_locator.
interface crop_roi_locator_if #(
  parameter int unsigned PIXEL_BIT_WIDTH  = 16,
  parameter int unsigned IMG_ROW_BITWIDTH = 10,
  parameter int unsigned IMG_COL_BITWIDTH = 10
);

  logic                        ap_start;
  logic                        ap_done;
  logic                        ap_idle;
  logic                        ap_ready;

  logic [PIXEL_BIT_WIDTH-1:0]  img_input_TDATA;
  logic                        img_input_TVALID;
  logic                        img_input_TREADY;

  logic [IMG_ROW_BITWIDTH-1:0] crop_Y1_TDATA;
  logic                        crop_Y1_TVALID;
  logic                        crop_Y1_TREADY;

  logic [IMG_COL_BITWIDTH-1:0] crop_X1_TDATA;
  logic                        crop_X1_TVALID;
  logic                        crop_X1_TREADY;

  modport slave (
    input  ap_start,
    output ap_done, ap_idle, ap_ready,
    input  img_input_TDATA, img_input_TVALID,
    output img_input_TREADY,
    output crop_Y1_TDATA, crop_Y1_TVALID,
    input  crop_Y1_TREADY,
    output crop_X1_TDATA, crop_X1_TVALID,
    input  crop_X1_TREADY
  );

  modport master (
    output ap_start,
    input  ap_done, ap_idle, ap_ready,
    output img_input_TDATA, img_input_TVALID,
    input  img_input_TREADY,
    input  crop_Y1_TDATA, crop_Y1_TVALID,
    output crop_Y1_TREADY,
    input  crop_X1_TDATA, crop_X1_TVALID,
    output crop_X1_TREADY
  );

endinterface

// File: rtl/crop_peak_tracker.sv
// Running signed maximum over a raster scan; strict compare keeps the first occurrence.
module crop_peak_tracker
  import crop_pkg::*;
#(
  parameter int unsigned PIXEL_BIT_WIDTH  = DEF_PIXEL_BIT_WIDTH,
  parameter int unsigned IMG_ROW_BITWIDTH = DEF_IMG_ROW_BITWIDTH,
  parameter int unsigned IMG_COL_BITWIDTH = DEF_IMG_COL_BITWIDTH
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               clear_i,
  input  logic                               en_i,
  input  logic signed [PIXEL_BIT_WIDTH-1:0]  pixel_i,
  input  logic        [IMG_ROW_BITWIDTH-1:0] row_i,
  input  logic        [IMG_COL_BITWIDTH-1:0] col_i,
  output logic        [IMG_ROW_BITWIDTH-1:0] peak_row_next_o,
  output logic        [IMG_COL_BITWIDTH-1:0] peak_col_next_o
);

  logic signed [PIXEL_BIT_WIDTH-1:0]  peak_val_q, peak_val_d;
  logic        [IMG_ROW_BITWIDTH-1:0] peak_row_q, peak_row_d;
  logic        [IMG_COL_BITWIDTH-1:0] peak_col_q, peak_col_d;

  always_comb begin
    peak_val_d = peak_val_q;
    peak_row_d = peak_row_q;
    peak_col_d = peak_col_q;
    if (clear_i) begin
      peak_val_d = {1'b1, {(PIXEL_BIT_WIDTH-1){1'b0}}};
      peak_row_d = '0;
      peak_col_d = '0;
    end else if (en_i && (pixel_i > peak_val_q)) begin
      peak_val_d = pixel_i;
      peak_row_d = row_i;
      peak_col_d = col_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      peak_val_q <= '0;
      peak_row_q <= '0;
      peak_col_q <= '0;
    end else begin
      peak_val_q <= peak_val_d;
      peak_row_q <= peak_row_d;
      peak_col_q <= peak_col_d;
    end
  end

  // Exposing the next-state winner lets the last pixel count toward the origin in its own cycle.
  assign peak_row_next_o = peak_row_d;
  assign peak_col_next_o = peak_col_d;

endmodule

// File: rtl/crop_roi_locator.sv
// Scans one raster frame for its peak pixel and emits the clamped crop origin on two streams.
module crop_roi_locator
  import crop_pkg::*;
#(
  parameter int unsigned PIXEL_BIT_WIDTH  = DEF_PIXEL_BIT_WIDTH,
  parameter int unsigned IN_ROWS          = DEF_IN_ROWS,
  parameter int unsigned IN_COLS          = DEF_IN_COLS,
  parameter int unsigned OUT_ROWS         = DEF_OUT_ROWS,
  parameter int unsigned OUT_COLS         = DEF_OUT_COLS,
  parameter int unsigned IMG_ROW_BITWIDTH = DEF_IMG_ROW_BITWIDTH,
  parameter int unsigned IMG_COL_BITWIDTH = DEF_IMG_COL_BITWIDTH
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  crop_roi_locator_if.slave bus
);

  localparam int unsigned ROW_HALF = OUT_ROWS / 2;
  localparam int unsigned COL_HALF = OUT_COLS / 2;
  localparam int unsigned ROW_MAX  = IN_ROWS - OUT_ROWS;
  localparam int unsigned COL_MAX  = IN_COLS - OUT_COLS;

  if (OUT_ROWS > IN_ROWS) begin : g_chk_out_rows
    $error("OUT_ROWS must not exceed IN_ROWS");
  end
  if (OUT_COLS > IN_COLS) begin : g_chk_out_cols
    $error("OUT_COLS must not exceed IN_COLS");
  end
  if (IN_ROWS >= (1 << IMG_ROW_BITWIDTH)) begin : g_chk_row_width
    $error("IN_ROWS does not fit in IMG_ROW_BITWIDTH");
  end
  if (IN_COLS >= (1 << IMG_COL_BITWIDTH)) begin : g_chk_col_width
    $error("IN_COLS does not fit in IMG_COL_BITWIDTH");
  end

  state_e                      state_q, state_d;
  logic [IMG_ROW_BITWIDTH-1:0] row_q, row_d;
  logic [IMG_COL_BITWIDTH-1:0] col_q, col_d;
  logic                        y_vld_q, y_vld_d;
  logic                        x_vld_q, x_vld_d;
  logic [IMG_ROW_BITWIDTH-1:0] y_data_q, y_data_d;
  logic [IMG_COL_BITWIDTH-1:0] x_data_q, x_data_d;

  logic                        accept, last_col, last_row, last_pix, clear;
  logic [IMG_ROW_BITWIDTH-1:0] peak_row_next, y_origin;
  logic [IMG_COL_BITWIDTH-1:0] peak_col_next, x_origin;

  assign accept   = (state_q == SCAN) && bus.img_input_TVALID;
  assign last_col = (col_q == IMG_COL_BITWIDTH'(IN_COLS - 1));
  assign last_row = (row_q == IMG_ROW_BITWIDTH'(IN_ROWS - 1));
  assign last_pix = accept && last_row && last_col;
  assign clear    = (state_q == IDLE) && bus.ap_start;

  crop_peak_tracker #(
    .PIXEL_BIT_WIDTH  (PIXEL_BIT_WIDTH),
    .IMG_ROW_BITWIDTH (IMG_ROW_BITWIDTH),
    .IMG_COL_BITWIDTH (IMG_COL_BITWIDTH)
  ) u_peak (
    .clk_i           (ap_clk),
    .rst_ni          (ap_rst_n),
    .clear_i         (clear),
    .en_i            (accept),
    .pixel_i         ($signed(bus.img_input_TDATA)),
    .row_i           (row_q),
    .col_i           (col_q),
    .peak_row_next_o (peak_row_next),
    .peak_col_next_o (peak_col_next)
  );

  assign y_origin = IMG_ROW_BITWIDTH'(clamp_origin(32'(peak_row_next), ROW_HALF, ROW_MAX));
  assign x_origin = IMG_COL_BITWIDTH'(clamp_origin(32'(peak_col_next), COL_HALF, COL_MAX));

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    y_vld_d  = y_vld_q;
    x_vld_d  = x_vld_q;
    y_data_d = y_data_q;
    x_data_d = x_data_q;
    unique case (state_q)
      IDLE: begin
        if (bus.ap_start) begin
          state_d = SCAN;
          row_d   = '0;
          col_d   = '0;
        end
      end
      SCAN: begin
        if (accept) begin
          if (last_col) begin
            col_d = '0;
            row_d = last_row ? '0 : row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
          if (last_pix) begin
            state_d  = EMIT;
            y_vld_d  = 1'b1;
            x_vld_d  = 1'b1;
            y_data_d = y_origin;
            x_data_d = x_origin;
          end
        end
      end
      EMIT: begin
        if (y_vld_q && bus.crop_Y1_TREADY) y_vld_d = 1'b0;
        if (x_vld_q && bus.crop_X1_TREADY) x_vld_d = 1'b0;
        if (!y_vld_d && !x_vld_d) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= IDLE;
      row_q    <= '0;
      col_q    <= '0;
      y_vld_q  <= 1'b0;
      x_vld_q  <= 1'b0;
      y_data_q <= '0;
      x_data_q <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      y_vld_q  <= y_vld_d;
      x_vld_q  <= x_vld_d;
      y_data_q <= y_data_d;
      x_data_q <= x_data_d;
    end
  end

  assign bus.ap_idle          = (state_q == IDLE);
  assign bus.ap_done          = (state_q == DONE);
  assign bus.ap_ready         = last_pix;
  assign bus.img_input_TREADY = (state_q == SCAN);
  assign bus.crop_Y1_TVALID   = y_vld_q;
  assign bus.crop_Y1_TDATA    = y_data_q;
  assign bus.crop_X1_TVALID   = x_vld_q;
  assign bus.crop_X1_TDATA    = x_data_q;

endmodule

// File: tb/tb_crop_roi_locator.sv
// Directed-frame bench for crop_roi_locator with a frame-level reference model and per-cycle monitor.
module tb_crop_roi_locator;
  import crop_pkg::*;

  localparam int ROWS = 100;
  localparam int COLS = 160;
  localparam int N    = ROWS * COLS;

  logic ap_clk   = 1'b0;
  logic ap_rst_n = 1'b0;
  always #5 ap_clk = ~ap_clk;

  crop_roi_locator_if #(
    .PIXEL_BIT_WIDTH  (16),
    .IMG_ROW_BITWIDTH (10),
    .IMG_COL_BITWIDTH (10)
  ) bus ();

  crop_roi_locator #(
    .PIXEL_BIT_WIDTH  (16),
    .IN_ROWS          (ROWS),
    .IN_COLS          (COLS),
    .OUT_ROWS         (48),
    .OUT_COLS         (48),
    .IMG_ROW_BITWIDTH (10),
    .IMG_COL_BITWIDTH (10)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  int checks   = 0;
  int failures = 0;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  int pix [N];
  int cyc = 0;
  always @(posedge ap_clk) cyc++;

  // Expected origin of the frame in flight (written by stimulus only)
  int exp_y = 0;
  int exp_x = 0;

  // Monitor-owned observation state
  int acc_cnt = 0;
  int last_cyc = -1;
  int last_acc_cyc = -1;
  bit busy = 0;
  bit y_hs = 0;
  bit x_hs = 0;
  int y_hs_cyc = 0;
  int x_hs_cyc = 0;
  int got_y = -1;
  int got_x = -1;
  int frames_done = 0;
  int done_cyc = 0;

  always @(negedge ap_clk) begin : monitor
    bit acc, exp_yv, exp_xv, exp_done;
    if (!ap_rst_n) begin
      acc_cnt  = 0;
      last_cyc = -1;
      busy     = 0;
      y_hs     = 0;
      x_hs     = 0;
    end else begin
      chk("ap_idle", int'(bus.ap_idle), int'(!busy));
      chk("img_tready", int'(bus.img_input_TREADY), int'(busy && acc_cnt < N));
      acc = bus.img_input_TVALID && bus.img_input_TREADY;
      chk("ap_ready", int'(bus.ap_ready), int'(acc && acc_cnt == N - 1));

      exp_yv = (last_cyc >= 0) && !y_hs;
      exp_xv = (last_cyc >= 0) && !x_hs;
      chk("y_tvalid", int'(bus.crop_Y1_TVALID), int'(exp_yv));
      chk("x_tvalid", int'(bus.crop_X1_TVALID), int'(exp_xv));
      if (bus.crop_Y1_TVALID) chk("y_tdata", int'(bus.crop_Y1_TDATA), exp_y);
      if (bus.crop_X1_TVALID) chk("x_tdata", int'(bus.crop_X1_TDATA), exp_x);

      exp_done = (last_cyc >= 0) && y_hs && x_hs &&
                 (cyc == ((y_hs_cyc > x_hs_cyc) ? y_hs_cyc : x_hs_cyc) + 1);
      chk("ap_done", int'(bus.ap_done), int'(exp_done));
      if (bus.ap_done) begin
        frames_done++;
        done_cyc = cyc;
        busy     = 0;
        last_cyc = -1;
      end

      if (bus.crop_Y1_TVALID && bus.crop_Y1_TREADY && !y_hs) begin
        y_hs = 1; y_hs_cyc = cyc; got_y = int'(bus.crop_Y1_TDATA);
      end
      if (bus.crop_X1_TVALID && bus.crop_X1_TREADY && !x_hs) begin
        x_hs = 1; x_hs_cyc = cyc; got_x = int'(bus.crop_X1_TDATA);
      end
      if (acc) begin
        acc_cnt++;
        if (acc_cnt == N) begin
          last_cyc     = cyc;
          last_acc_cyc = cyc;
        end
      end
      if (bus.ap_idle && bus.ap_start) begin
        busy    = 1;
        acc_cnt = 0;
        y_hs    = 0;
        x_hs    = 0;
        got_y   = -1;
        got_x   = -1;
      end
    end
  end

  task automatic fill(input int v);
    for (int i = 0; i < N; i++) pix[i] = v;
  endtask

  task automatic put(input int r, input int c, input int v);
    pix[r * COLS + c] = v;
  endtask

  // Reference: first strictly-greatest pixel in raster order, then clamp each axis.
  task automatic model(output int my, output int mx);
    int best, bi;
    best = pix[0];
    bi   = 0;
    for (int i = 1; i < N; i++)
      if (pix[i] > best) begin best = pix[i]; bi = i; end
    my = int'(clamp_origin(bi / COLS, 24, ROWS - 48));
    mx = int'(clamp_origin(bi % COLS, 24, COLS - 48));
  endtask

  task automatic run_frame(input string tag, input int vpct, input int ystall,
                           input int abort_at, input int lit_y, input int lit_x);
    int idx, budget, fd, my, mx;
    bit v, rdy;
    model(my, mx);
    chk({tag, "_model_y"}, my, lit_y);
    chk({tag, "_model_x"}, mx, lit_x);
    exp_y = my;
    exp_x = mx;
    bus.crop_Y1_TREADY = (ystall == 0);
    bus.crop_X1_TREADY = 1'b1;
    fd = frames_done;

    @(posedge ap_clk); #1;
    bus.ap_start = 1'b1;
    idx    = 0;
    budget = 0;
    while (idx < N && budget < 40000) begin
      if (budget == 3) bus.ap_start = 1'b0;
      v = ($urandom_range(99) < vpct);
      bus.img_input_TVALID = v;
      bus.img_input_TDATA  = v ? 16'(pix[idx]) : 16'($urandom);
      rdy = bus.img_input_TREADY;
      @(posedge ap_clk); #1;
      if (v && rdy) idx++;
      budget++;
      if (abort_at > 0 && idx == abort_at) begin
        ap_rst_n = 1'b0;
        #1;
        chk({tag, "_rst_idle"}, int'(bus.ap_idle), 1);
        chk({tag, "_rst_tready"}, int'(bus.img_input_TREADY), 0);
        chk({tag, "_rst_yvalid"}, int'(bus.crop_Y1_TVALID), 0);
        chk({tag, "_rst_xvalid"}, int'(bus.crop_X1_TVALID), 0);
        bus.img_input_TVALID = 1'b0;
        bus.ap_start         = 1'b0;
        @(negedge ap_clk);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        repeat (3) @(posedge ap_clk);
        #1;
        chk({tag, "_no_output"}, frames_done - fd, 0);
        return;
      end
    end
    bus.img_input_TVALID = 1'b0;
    bus.ap_start         = 1'b0;
    chk({tag, "_pixels_accepted"}, acc_cnt, N);

    if (ystall > 0) begin
      repeat (ystall) @(posedge ap_clk);
      #1;
      chk({tag, "_y_held"}, int'(bus.crop_Y1_TVALID), 1);
      chk({tag, "_x_first"}, int'(x_hs), 1);
      chk({tag, "_no_early_done"}, frames_done - fd, 0);
      bus.crop_Y1_TREADY = 1'b1;
    end

    budget = 0;
    while (frames_done == fd && budget < 200) begin
      @(posedge ap_clk);
      budget++;
    end
    #1;
    chk({tag, "_done_seen"}, frames_done - fd, 1);
    chk({tag, "_dut_y"}, got_y, lit_y);
    chk({tag, "_dut_x"}, got_x, lit_x);
    if (ystall == 0) chk({tag, "_done_latency"}, done_cyc - last_acc_cyc, 2);
    repeat (2) @(posedge ap_clk);
    #1;
  endtask

  initial begin
    bus.ap_start         = 1'b0;
    bus.img_input_TVALID = 1'b0;
    bus.img_input_TDATA  = '0;
    bus.crop_Y1_TREADY   = 1'b0;
    bus.crop_X1_TREADY   = 1'b0;
    #2;
    chk("reset_idle", int'(bus.ap_idle), 1);
    chk("reset_done", int'(bus.ap_done), 0);
    chk("reset_ready", int'(bus.ap_ready), 0);
    chk("reset_tready", int'(bus.img_input_TREADY), 0);
    chk("reset_yvalid", int'(bus.crop_Y1_TVALID), 0);
    chk("reset_xvalid", int'(bus.crop_X1_TVALID), 0);
    chk("reset_ydata", int'(bus.crop_Y1_TDATA), 0);
    chk("reset_xdata", int'(bus.crop_X1_TDATA), 0);
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;

    fill(-100); put(30, 70, 500);
    run_frame("centre", 100, 0, 0, 6, 46);

    fill(-100); put(0, 0, 500);
    run_frame("origin", 100, 0, 0, 0, 0);

    fill(-100); put(99, 159, 500);
    run_frame("corner", 100, 0, 0, 52, 112);

    for (int i = 0; i < N; i++) pix[i] = int'($urandom_range(599)) - 300;
    put(40, 60, 300); put(80, 100, 300);
    run_frame("tie_stall", 95, 50, 0, 16, 36);

    fill(-100); put(20, 20, 2000);
    run_frame("abort", 100, 0, 5000, 0, 0);

    fill(-200); put(60, 90, -1);
    run_frame("signed", 100, 0, 0, 36, 66);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
